// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C slave transaction sequencer.
// Optional build macro I2C_WRITE_ACK_EN adds the master-write (RX) states.
package i2c_slave_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_RX,
        ST_ADDR_CHK,
        ST_ACK_ADDR,
        ST_NACK_ADDR,
        ST_LOAD,
        ST_TX,
        ST_M_ACK,
        ST_ACKED,
        ST_WAIT_STOP
`ifdef I2C_WRITE_ACK_EN
        ,
        ST_RX_DATA,
        ST_RX_ACK
`endif
    } state_t;

    typedef enum logic [1:0] {
        SDA_RELEASE = 2'b00,
        SDA_ACK     = 2'b01,
        SDA_NACK    = 2'b10,
        SDA_TX      = 2'b11
    } sda_mode_t;

    // Slave-driven ACK/NACK bits only take the line once the timer has flagged SCL low.
    function automatic sda_mode_t ackDrive(input logic seen, input sda_mode_t mode);
        return seen ? mode : SDA_RELEASE;
    endfunction

endpackage

// File: rtl/i2c_slave_controller.sv
// Transaction-level Moore sequencer for the I2C slave; outputs decode registered state only.
// Build macro I2C_WRITE_ACK_EN enables ACKing master writes to the matching address.
module i2c_slave_controller
    import i2c_slave_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_found,
    input  logic             stop_found,
    input  logic             byte_received,
    input  logic             ack_prep,
    input  logic             check_ack,
    input  logic             ack_done,
    input  logic             rw_mode,
    input  logic             address_match,
    input  logic             sda_in,
    input  logic             tx_fifo_empty,
    output logic             rx_enable,
    output logic             tx_enable,
    output logic             load_data,
    output logic             read_enable,
    output logic [1:0]       sda_mode,
    output logic             tx_underrun,
    output logic [CNT_W-1:0] byte_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ack_seen;
    logic             w_ack_seen_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_fifo_empty;
`ifdef I2C_WRITE_ACK_EN
    logic             r_write;
    logic             w_write_nxt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_ack_seen   <= 1'b0;
            r_count      <= '0;
            r_fifo_empty <= 1'b0;
`ifdef I2C_WRITE_ACK_EN
            r_write      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ack_seen   <= w_ack_seen_nxt;
            r_count      <= w_count_nxt;
            r_fifo_empty <= tx_fifo_empty;
`ifdef I2C_WRITE_ACK_EN
            r_write      <= w_write_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ack_seen_nxt = r_ack_seen;
        w_count_nxt    = r_count;
`ifdef I2C_WRITE_ACK_EN
        w_write_nxt    = r_write;
`endif
        rx_enable      = 1'b0;
        tx_enable      = 1'b0;
        load_data      = 1'b0;
        read_enable    = 1'b0;
        tx_underrun    = 1'b0;
        sda_mode       = SDA_RELEASE;
        byte_count     = r_count;

        case (r_state)
            ST_IDLE: begin
                if (start_found) w_state_nxt = ST_ADDR_RX;
            end
            ST_ADDR_RX: begin
                rx_enable = 1'b1;
                if (byte_received) w_state_nxt = ST_ADDR_CHK;
            end
            ST_ADDR_CHK: begin
`ifdef I2C_WRITE_ACK_EN
                w_write_nxt = !rw_mode;
                w_state_nxt = address_match ? ST_ACK_ADDR : ST_NACK_ADDR;
`else
                w_state_nxt = (address_match && rw_mode) ? ST_ACK_ADDR : ST_NACK_ADDR;
`endif
            end
            ST_ACK_ADDR: begin
                sda_mode = ackDrive(r_ack_seen, SDA_ACK);
                if (ack_prep) w_ack_seen_nxt = 1'b1;
`ifdef I2C_WRITE_ACK_EN
                if (ack_done) w_state_nxt = r_write ? ST_RX_DATA : ST_LOAD;
`else
                if (ack_done) w_state_nxt = ST_LOAD;
`endif
            end
            ST_NACK_ADDR: begin
                sda_mode = ackDrive(r_ack_seen, SDA_NACK);
                if (ack_prep) w_ack_seen_nxt = 1'b1;
                if (ack_done) w_state_nxt = ST_WAIT_STOP;
            end
            // FIFO status is taken from the previous cycle so no input reaches an output.
            ST_LOAD: begin
                load_data   = 1'b1;
                read_enable = !r_fifo_empty;
                tx_underrun = r_fifo_empty;
                w_state_nxt = ST_TX;
            end
            ST_TX: begin
                sda_mode  = SDA_TX;
                tx_enable = 1'b1;
                if (byte_received) begin
                    w_state_nxt = ST_M_ACK;
                    if (r_count != CNT_MAX) w_count_nxt = r_count + CNT_ONE;
                end
            end
            ST_M_ACK: begin
                if (check_ack) w_state_nxt = sda_in ? ST_WAIT_STOP : ST_ACKED;
            end
            ST_ACKED: begin
                if (ack_done) w_state_nxt = ST_LOAD;
            end
            ST_WAIT_STOP: begin
                w_state_nxt = ST_WAIT_STOP;
            end
`ifdef I2C_WRITE_ACK_EN
            ST_RX_DATA: begin
                rx_enable = 1'b1;
                if (byte_received) begin
                    w_state_nxt = ST_RX_ACK;
                    if (r_count != CNT_MAX) w_count_nxt = r_count + CNT_ONE;
                end
            end
            ST_RX_ACK: begin
                sda_mode = ackDrive(r_ack_seen, SDA_ACK);
                if (ack_prep) w_ack_seen_nxt = 1'b1;
                if (ack_done) w_state_nxt = ST_RX_DATA;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Bus conditions override everything; STOP has priority over a coincident START.
        if (start_found) begin
            w_state_nxt = ST_ADDR_RX;
            w_count_nxt = '0;
        end
        if (stop_found) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end
        if (w_state_nxt != r_state) w_ack_seen_nxt = 1'b0;
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Scoreboard bench for i2c_slave_controller: stimulus pushes expected bus events, a monitor pops them.
// Expectations follow I2C_WRITE_ACK_EN when it is defined for the build.
module tb_i2c_slave_controller;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_found = 1'b0;
    logic       stop_found = 1'b0;
    logic       byte_received = 1'b0;
    logic       ack_prep = 1'b0;
    logic       check_ack = 1'b0;
    logic       ack_done = 1'b0;
    logic       rw_mode = 1'b0;
    logic       address_match = 1'b0;
    logic       sda_in = 1'b1;
    logic       tx_fifo_empty = 1'b0;
    logic       rx_enable;
    logic       tx_enable;
    logic       load_data;
    logic       read_enable;
    logic [1:0] sda_mode;
    logic       tx_underrun;
    logic [7:0] byte_count;

`ifdef I2C_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [5:0] val;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail = 0;

    i2c_slave_controller #(.CNT_W(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start_found   (start_found),
        .stop_found    (stop_found),
        .byte_received (byte_received),
        .ack_prep      (ack_prep),
        .check_ack     (check_ack),
        .ack_done      (ack_done),
        .rw_mode       (rw_mode),
        .address_match (address_match),
        .sda_in        (sda_in),
        .tx_fifo_empty (tx_fifo_empty),
        .rx_enable     (rx_enable),
        .tx_enable     (tx_enable),
        .load_data     (load_data),
        .read_enable   (read_enable),
        .sda_mode      (sda_mode),
        .tx_underrun   (tx_underrun),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Event kinds: 0 byte phase {sda_mode,tx_en,rx_en}, 1 ACK bit {00,sda_mode}, 2 load {0,load,pop,underrun}.
    task automatic expectEvent(input string name, input logic [1:0] kind, input logic [3:0] data);
        expQ.push_back('{name, {kind, data}});
    endtask

    task automatic observe(input logic [5:0] got);
        exp_t e;
        if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL unexpected_event: got %0d, expected none", got);
        end else begin
            e = expQ.pop_front();
            checkOutput(e.name, int'(got), int'(e.val));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (byte_received) observe({2'd0, sda_mode, tx_enable, rx_enable});
                if (check_ack) observe({2'd1, 2'b00, sda_mode});
                if (load_data || read_enable || tx_underrun)
                    observe({2'd2, 1'b0, load_data, read_enable, tx_underrun});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start_found = 1'b1;
        tick();
        start_found = 1'b0;
    endtask

    task automatic sendByte(input string name, input logic [3:0] expPhase);
        expectEvent(name, 2'd0, expPhase);
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
        tick();
    endtask

    task automatic ackPhase(input string name, input logic sdaBit, input logic [1:0] expSda,
                            input bit doLoad, input bit fifoEmpty);
        tx_fifo_empty = fifoEmpty;
        ack_prep = 1'b1;
        tick();
        ack_prep = 1'b0;
        expectEvent(name, 2'd1, {2'b00, expSda});
        check_ack = 1'b1;
        sda_in = sdaBit;
        tick();
        check_ack = 1'b0;
        sda_in = 1'b1;
        if (doLoad) expectEvent({name, "_load"}, 2'd2, {1'b0, 1'b1, !fifoEmpty, fifoEmpty});
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
        tick();
    endtask

    task automatic finishTxn(input bit withStart);
        stop_found = 1'b1;
        start_found = withStart;
        tick();
        stop_found = 1'b0;
        start_found = 1'b0;
        checkOutput("stop_sda", int'(sda_mode), 0);
        checkOutput("stop_count", int'(byte_count), 0);
        sendByte("idle_byte", 4'b0000);
    endtask

    // Reference: slave ACKs a matching read (or write when enabled); each transmitted byte counts.
    task automatic applyStimulus(input bit match, input bit rw, input int n,
                                 input int nackAt, input int emptyAt, input bit withStart);
        int cnt = 0;
        bit addrAck = match && (rw || WRITE_ACK);
        pulseStart();
        address_match = match;
        rw_mode = rw;
        sendByte("addr_rx", 4'b0001);
        ackPhase("addr_ack", 1'b1, addrAck ? 2'b01 : 2'b10, addrAck && rw, emptyAt == 0);
        if (!addrAck) begin
            sendByte("wait_stop_byte", 4'b0000);
        end else if (rw) begin
            for (int i = 0; i < n; i++) begin
                bit nack = (i == nackAt);
                sendByte("tx_byte", 4'b1110);
                cnt++;
                ackPhase("m_ack", nack, 2'b00, !nack, emptyAt == i + 1);
                if (nack) begin
                    sendByte("after_nack_byte", 4'b0000);
                    break;
                end
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                sendByte("rx_byte", 4'b0001);
                cnt++;
                ackPhase("rx_ack", 1'b1, 2'b01, 1'b0, 1'b0);
            end
        end
        checkOutput("byte_count", int'(byte_count), (cnt > 255) ? 255 : cnt);
        finishTxn(withStart);
    endtask

    initial begin
        repeat (2) tick();
        checkOutput("rst_outputs",
                    int'({rx_enable, tx_enable, load_data, read_enable, tx_underrun, sda_mode}), 0);
        checkOutput("rst_count", int'(byte_count), 0);
        n_rst = 1'b1;
        tick();

        applyStimulus(1'b1, 1'b1, 2, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2, -1, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1, -1, -1, 1'b0);
        applyStimulus(1'b1, 1'b1, 3, 2, -1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2, -1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2, -1, 2, 1'b1);
        applyStimulus(1'b1, 1'b0, 2, -1, -1, 1'b0);
        applyStimulus(1'b1, 1'b1, 257, -1, -1, 1'b0);

        pulseStart();
        address_match = 1'b1;
        rw_mode = 1'b1;
        sendByte("rst_addr", 4'b0001);
        ack_prep = 1'b1;
        tick();
        ack_prep = 1'b0;
        tick();
        checkOutput("ack_before_rst", int'(sda_mode), 1);
        n_rst = 1'b0;
        #2;
        checkOutput("sda_async_rst", int'(sda_mode), 0);
        checkOutput("outputs_async_rst",
                    int'({rx_enable, tx_enable, load_data, read_enable, tx_underrun}), 0);
        tick();
        n_rst = 1'b1;
        tick();
        sendByte("post_rst_byte", 4'b0000);

        pulseStart();
        address_match = 1'b0;
        sendByte("rs_addr", 4'b0001);
        ackPhase("rs_nack", 1'b1, 2'b10, 1'b0, 1'b0);
        pulseStart();
        sendByte("rs_restart_addr", 4'b0001);
        finishTxn(1'b0);

        for (int t = 0; t < 30; t++) begin
            int n = int'($urandom_range(1, 4));
            int na = int'($urandom_range(0, n));
            int ea = int'($urandom_range(0, n + 1));
            applyStimulus(($urandom % 4) != 0, $urandom % 2 == 1, n,
                          (na == n) ? -1 : na, (ea > n) ? -1 : ea, $urandom % 2 == 1);
        end

        repeat (2) tick();
        checkOutput("queue_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
